// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I memory-stage load/store unit with req/ack data bus
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  StallM,
    output logic                  MemFaultM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            lane_q, lane_d;
    logic [2:0]            f3_q, f3_d;

    logic                  access, fault, f3_ok, misalign, issue;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc, load_fmt;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign access = MemReadM ^ MemWriteM;

    always_comb begin
        f3_ok = 1'b0;
        if (MemWriteM) begin
            f3_ok = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
        end else begin
            f3_ok = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                    (Funct3M == 3'b100) || (Funct3M == 3'b101);
        end
    end

    assign misalign = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                      ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    assign fault    = (MemReadM & MemWriteM) |
                      ((MemReadM | MemWriteM) & (~f3_ok | misalign));
    assign issue    = (state_q == S_IDLE) & access & ~fault;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ALUResultM[1:0];
                wdata_calc = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_calc    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = WriteDataM;
            end
        endcase
    end

    // Lane and size come from the values latched at issue, not the live M-stage inputs.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   load_fmt = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
            2'b01:   load_fmt = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        f3_d    = f3_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    lane_d  = ALUResultM[1:0];
                    f3_d    = Funct3M;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    be_d    = 4'b0000;
                    if (!we_q) begin
                        rd_d = load_fmt;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
        end
    end

    assign StallM    = issue | (state_q == S_BUSY);
    assign MemFaultM = (state_q == S_IDLE) & fault;
    assign rd        = rd_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] rd;
    logic        StallM, MemFaultM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          stalls;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   passes = 0;
    logic        pending = 1'b0;
    logic [31:0] pend_rd;
    int          pend_stalls;
    int          stall_cnt = 0;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .rd(rd), .StallM(StallM), .MemFaultM(MemFaultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: bus fields on the ack cycle, then result and stall count in the DONE cycle.
    always @(negedge clk) begin
        if (rst) begin
            pending   = 1'b0;
            stall_cnt = 0;
        end else begin
            if (StallM) stall_cnt++;
            if (pending) begin
                chk("done_rd", rd, pend_rd);
                chk("done_stall", {31'd0, StallM}, 32'd0);
                chk("done_req", {31'd0, mem_req}, 32'd0);
                chk("stall_cycles", stall_cnt, pend_stalls);
                pending   = 1'b0;
                stall_cnt = 0;
            end else if (mem_req && mem_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_txn", 32'd1, 32'd0);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("bus_we", {31'd0, mem_we}, {31'd0, t.we});
                    chk("bus_addr", mem_addr, t.addr);
                    chk("bus_be", {28'd0, mem_be}, {28'd0, t.be});
                    if (t.we) chk("bus_wdata", mem_wdata, t.wdata);
                    pending     = 1'b1;
                    pend_rd     = t.rd;
                    pend_stalls = t.stalls;
                end
            end
        end
    end

    task automatic txn(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int delay,
                       input logic [3:0] be, input logic [31:0] exp_rd,
                       input logic [31:0] exp_wd);
        txn_t t;
        @(posedge clk); #1;
        MemReadM = r; MemWriteM = w; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        mem_ack = 1'b0;
        t.we = w; t.addr = {addr[31:2], 2'b00}; t.be = be; t.wdata = exp_wd;
        t.rd = exp_rd; t.stalls = delay + 2;
        sb.push_back(t);
        @(posedge clk); #1;
        repeat (delay) begin @(posedge clk); #1; end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic fault_case(input string name, input logic r, input logic w,
                              input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        MemReadM = r; MemWriteM = w; Funct3M = f3; ALUResultM = addr; WriteDataM = 32'hFFFF_FFFF;
        #1;
        chk({name, "_fault"}, {31'd0, MemFaultM}, 32'd1);
        chk({name, "_stall"}, {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        chk({name, "_noreq"}, {31'd0, mem_req}, 32'd0);
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_fault", {31'd0, MemFaultM}, 32'd0);
        rst = 1'b0;

        txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0);
        txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'hFFFFFF80, 32'h0);
        txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 4'b1000, 32'h00000080, 32'h0);
        txn(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 4'b1100, 32'h000080FF, 32'h0);
        txn(1, 0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 2, 4'b0011, 32'hFFFFF00D, 32'h0);
        txn(0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h0, 0, 4'b0010, 32'hFFFFF00D, 32'hABABABAB);
        txn(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 4'b1100, 32'hFFFFF00D, 32'hBEEFBEEF);
        txn(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hFFFFF00D, 32'hCAFEF00D);
        txn(1, 0, 3'b010, 32'h104, 32'h0, 32'h11111111, 0, 4'b1111, 32'h11111111, 32'h0);
        txn(1, 0, 3'b010, 32'h108, 32'h0, 32'h22222222, 0, 4'b1111, 32'h22222222, 32'h0);
        go_idle();

        fault_case("lw_mis", 1, 0, 3'b010, 32'h102);
        fault_case("sh_mis", 0, 1, 3'b001, 32'h003);
        fault_case("ld_f3", 1, 0, 3'b011, 32'h100);
        fault_case("sbu_f3", 0, 1, 3'b100, 32'h100);
        fault_case("both", 1, 1, 3'b010, 32'h100);
        chk("fault_rd_kept", rd, 32'h22222222);

        // Abandon a load in BUSY with reset; its late ack must not land.
        @(posedge clk); #1;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h300;
        @(posedge clk); #1;
        chk("busy_req", {31'd0, mem_req}, 32'd1);
        chk("busy_stall", {31'd0, StallM}, 32'd1);
        #1;
        rst = 1'b1; MemReadM = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_stall", {31'd0, StallM}, 32'd0);
        chk("arst_rd", rd, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_rd", rd, 32'h0);
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, StallM}, 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        chk("no_pending", {31'd0, pending}, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline, sitting between the EX/M register and the M/W register.
- Turns M-stage load/store controls into a req/ack transaction on the data-memory bus. Generates byte enables and replicated store data.
- Formats load data: lane select plus sign/zero extension. Drives the `rd` word sampled by the M/W register.
- Holds the pipeline via StallM while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- ALUResultM  in  DATA_WIDTH  byte address
- WriteDataM  in  DATA_WIDTH  store source register value
- rd  out  DATA_WIDTH  formatted load result, registered, to M/W register
- StallM  out  1  hold F/D/E/M stages this cycle
- MemFaultM  out  1  misaligned or illegal access, no bus transaction issued
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write
- mem_addr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_ack  in  1  bus completion; rdata valid this cycle for reads
- mem_rdata  in  DATA_WIDTH  read word

Behaviour:
- Reset values: state=IDLE, rd=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. StallM=0 and MemFaultM=0 follow from IDLE with no access.
- access = MemReadM ^ MemWriteM.
- fault = any of:
  - MemReadM & MemWriteM both set
  - illegal funct3 (loads 011/110/111; stores anything other than 000/001/010)
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
- State IDLE:
  - If access & !fault: latch mem_addr, mem_be, mem_wdata, mem_we, lane addr[1:0] and funct3; set mem_req=1; go to BUSY.
  - Combinational StallM=1 in this cycle.
  - If fault (with MemReadM or MemWriteM set): MemFaultM=1 combinationally, StallM=0, no request, rd unchanged, stay in IDLE.
  - Otherwise StallM=0.
- State BUSY:
  - StallM=1.
  - mem_req and all bus outputs held stable until mem_ack.
  - On mem_ack: mem_req<=0, mem_be<=0. For reads, rd<=formatted(mem_rdata). Go to DONE.
- State DONE:
  - StallM=0, so the instruction advances. M/W samples rd at the end of this cycle.
  - Next state is IDLE unconditionally. The same instruction is never re-issued.
- Minimum latency (ack in the first BUSY cycle): 3 cycles in M, 2 stall cycles. Each extra cycle without ack adds one stall.
- mem_ack in IDLE or DONE is ignored.
- Byte enables (shared by loads and stores):
  - B: 4'b0001<<addr[1:0]
  - H: addr[1]?4'b1100:4'b0011
  - W: 4'b1111
- Store data:
  - SB: {4{WriteDataM[7:0]}}
  - SH: {2{WriteDataM[15:0]}}
  - SW: WriteDataM
- Load format:
  - B/BU: select byte at latched lane, sign/zero extend.
  - H/HU: select half at lane[1], sign/zero extend.
  - W: pass through.
- Stores leave rd unchanged. Non-memory instructions leave rd unchanged.
- Back-to-back accesses: the next access is issued from IDLE on the cycle after DONE. No overlap, so at most one transaction is outstanding.
- Reset mid-transaction (BUSY): immediate return to IDLE, mem_req=0. The abandoned transaction's late ack is ignored.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ack 2 cycles after req -> StallM high 3 cycles, then DONE with rd=0xDEADBEEF, mem_be=1111, mem_addr=0x100.
- LB addr 0x103, rdata 0x80FF0000 -> be=1000, rd=0xFFFFFF80. LBU same -> rd=0x00000080. LHU addr 0x102 -> be=1100, rd=0x000080FF.
- SB addr 0x201, WriteDataM 0x123456AB -> mem_we=1, be=0010, wdata=0xABABABAB, mem_addr=0x200; rd unchanged.
- LW addr 0x102 (and SH addr 0x3) -> MemFaultM=1 same cycle, StallM=0, mem_req never asserted.
- Assert rst in BUSY before ack -> mem_req=0 and state IDLE asynchronously. Then ack arrives -> ignored, rd=0.
- Two consecutive loads, ack immediate -> req pulses separated by the DONE/IDLE cycle; each result is valid in its own DONE cycle.
